muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// cycle, operands taken over a start handshake and the result returned over a second one.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  // Divide-by-zero and signed-overflow results that bypass the iterative core.
  function automatic logic [XLEN-1:0] special_result(input logic is_rem, input logic div0,
                                                     input logic [XLEN-1:0] dividend);
    if (div0) return is_rem ? dividend : '1;
    return is_rem ? '0 : dividend;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_s1, w_s2, w_sign1, w_sign2;
  logic              w_div0, w_ovf, w_special, w_qbit;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_rem_nxt, w_final;
  logic [XLEN:0]     w_sum, w_shrem, w_trial;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;

  assign w_accept  = (r_state == S_IDLE) && start_valid;
  assign w_s1      = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_s2      = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_sign1   = w_s1 && in1[XLEN-1];
  assign w_sign2   = w_s2 && in2[XLEN-1];
  assign w_mag1    = neg_if(w_sign1, in1);
  assign w_mag2    = neg_if(w_sign2, in2);
  assign w_div0    = op[2] && (in2 == '0);
  assign w_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                     (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
  assign w_special = w_div0 || w_ovf;

  // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign w_shrem   = r_acc[2*XLEN-1:XLEN-1];
  assign w_trial   = w_shrem - {1'b0, r_opnd};
  assign w_qbit    = ~w_trial[XLEN];
  assign w_rem_nxt = w_qbit ? w_trial[XLEN-1:0] : w_shrem[XLEN-1:0];
  assign w_acc_nxt = r_op[2] ? {w_rem_nxt, r_acc[XLEN-2:0], w_qbit}
                             : {w_sum, r_acc[XLEN-1:1]};
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    w_final = w_prod[2*XLEN-1:XLEN];
    if (r_op == OP_MUL)
      w_final = w_prod[XLEN-1:0];
    else if (r_op[2])
      w_final = r_op[1] ? neg_if(r_neg_r, w_acc_nxt[2*XLEN-1:XLEN])
                        : neg_if(r_neg_q, w_acc_nxt[XLEN-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
      end
      S_CALC: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt <= CW'(XLEN - 1);
      if (w_special) r_result <= special_result(op[1], w_div0, in1);
    end else if (r_state == S_CALC) begin
      if (r_cnt == '0) r_result <= w_final;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= op;
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      r_opnd  <= op[2] ? w_mag2 : w_mag1;
      r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_mag1 : w_mag2)};
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: cycle-by-cycle comparison against an arithmetic model of the
// handshake timing and RV32M results, plus directed vectors with literal answers.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        result_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        start_ready, result_valid, busy;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .in1(in1), .in2(in2), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = 64'(a) * 64'(b);
    case (o)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(b); return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin if (b == 0) return '1; return 32'(sa / sb); end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin if (b == 0) return a; return 32'(sa % sb); end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_special(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model of the observable behaviour, advanced on every rising edge.
  bit          m_on = 0;
  bit          m_pend = 0;
  int          ecnt = 0;
  int          m_due = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on   = 1;
      m_pend = 0;
      m_last = '0;
    end else if (!m_pend) begin
      if (start_valid) begin
        m_pend = 1;
        m_due  = ecnt + 1 + (ref_special(op, in1, in2) ? 0 : XLEN);
        m_val  = ref_result(op, in1, in2);
      end
    end else if (ecnt >= m_due && result_ready) begin
      m_pend = 0;
      m_last = m_val;
    end
    ecnt = ecnt + 1;
  end

  always @(negedge clk) begin
    if (m_on) begin
      logic        exp_v;
      logic [31:0] exp_r;
      exp_v  = m_pend && (ecnt >= m_due);
      exp_r  = exp_v ? m_val : m_last;
      checks = checks + 1;
      if (start_ready !== !m_pend || busy !== m_pend || result_valid !== exp_v ||
          result !== exp_r) begin
        errors = errors + 1;
        $display("FAIL cycle %0d: ready/busy/valid/result = %b/%b/%b/%h, want %b/%b/%b/%h",
                 ecnt, start_ready, busy, result_valid, result, !m_pend, m_pend, exp_v, exp_r);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input int lat);
    int n;
    op = o; in1 = a; in2 = b; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op  = 3'($urandom);
    in1 = $urandom;
    in2 = $urandom;
    n = 1;
    while (!result_valid && n < 80) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    check({nm, " latency"}, n, lat);
    check(nm, result, want);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset start_ready", start_ready, 1);
    check("reset busy", busy, 0);
    check("reset result", result, 0);

    do_op("MUL 7*-3",        3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("MULH -3*7",       3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 33);
    do_op("MULHU min*4",     3'd3, 32'h8000_0000, 32'd4,         32'd2,         33);
    do_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    do_op("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    do_op("DIV 7/-2",        3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    do_op("REM 7/-2",        3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    do_op("DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        33);
    do_op("REMU 100/7",      3'd7, 32'd100,       32'd7,         32'd2,         33);
    do_op("DIVU max/1",      3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);
    do_op("DIV min/2",       3'd4, 32'h8000_0000, 32'd2,         32'hC000_0000, 33);
    do_op("REM min/1",       3'd6, 32'h8000_0000, 32'd1,         32'd0,         33);
    do_op("DIV 5/0",         3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("REMU 5/0",        3'd7, 32'd5,         32'd0,         32'd5,         1);
    do_op("DIVU 5/0",        3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("DIV min/-1",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REM min/-1",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : $urandom;
      do_op("random op", ro, ra, rb, ref_result(ro, ra, rb), ref_special(ro, ra, rb) ? 1 : 33);
    end

    // Backpressure: result held while start_valid keeps pulsing with new operands.
    op = 3'd5; in1 = 32'd100; in2 = 32'd7; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 1;
    while (!result_valid && n < 80) begin
      @(posedge clk); #1;
      n = n + 1;
    end
    check("backpressure latency", n, 33);
    for (int i = 0; i < 5; i++) begin
      start_valid = i[0] ? 1'b0 : 1'b1;
      op = 3'd0; in1 = 32'(i + 2); in2 = 32'd9;
      check("backpressure result", result, 32'd14);
      check("backpressure start_ready", start_ready, 0);
      @(posedge clk); #1;
    end
    check("backpressure still valid", result_valid, 1);
    result_ready = 1'b1;
    start_valid  = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    start_valid  = 1'b0;
    check("after handshake idle", start_ready, 1);
    check("after handshake busy", busy, 0);
    do_op("after backpressure MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Reset in cycle 10 of a DIVU discards it.
    op = 3'd5; in1 = 32'hDEAD_BEEF; in2 = 32'd3; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid-op reset busy", busy, 0);
    check("mid-op reset result_valid", result_valid, 0);
    check("mid-op reset result", result, 0);
    check("mid-op reset start_ready", start_ready, 1);
    do_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Reset wins over a simultaneous start request.
    rst = 1'b1; start_valid = 1'b1; op = 3'd0; in1 = 32'd5; in2 = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; start_valid = 1'b0;
    check("rst vs start busy", busy, 0);
    check("rst vs start ready", start_ready, 1);
    @(posedge clk); #1;
    check("rst vs start still idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
